// File: rtl/task_pulse_gen_pkg.sv
// Shared definitions for the task pulse engine: state encoding, default widths
// and the state chosen when a pulse completes.
package task_pulse_gen_pkg;

   localparam int DEFAULT_DELAY_W  = 16;
   localparam int DEFAULT_WIDTH_W  = 16;
   localparam int DEFAULT_REPEAT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Where a finished pulse goes: out of the train, into a gap, or straight
   // into the next pulse so that back-to-back pulses merge.
   function automatic state_t state_after_pulse(input logic last_pulse,
                                                input logic has_delay);
      state_t nxt;
      if (last_pulse)
         nxt = ST_DONE;
      else if (has_delay)
         nxt = ST_WAIT;
      else
         nxt = ST_HIGH;
      return nxt;
   endfunction

endpackage

// File: rtl/task_pulse_gen_load_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module load_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] count;
   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (en && (count != '0))
         count <= count - ONE;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/task_pulse_gen.sv
// Task engine: on an accepted START emits a train of DELAY-low / WIDTH-high
// pulses, then strobes TASK_DONE for one cycle to close the busy handshake.
module task_pulse_gen
   import task_pulse_gen_pkg::*;
#(
   parameter int DELAY_W  = DEFAULT_DELAY_W,
   parameter int WIDTH_W  = DEFAULT_WIDTH_W,
   parameter int REPEAT_W = DEFAULT_REPEAT_W
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic                STOP,
   input  logic [DELAY_W-1:0]  DELAY,
   input  logic [WIDTH_W-1:0]  WIDTH,
   input  logic [REPEAT_W-1:0] REPEAT,
   output logic                PULSE,
   output logic                BUSY,
   output logic                TASK_DONE,
   output logic [REPEAT_W-1:0] PULSE_CNT
);

   localparam logic [DELAY_W-1:0]  D_ONE = DELAY_W'(1);
   localparam logic [WIDTH_W-1:0]  W_ONE = WIDTH_W'(1);
   localparam logic [REPEAT_W-1:0] R_ONE = REPEAT_W'(1);

   state_t              state;
   logic [DELAY_W-1:0]  delay_lat;
   logic [WIDTH_W-1:0]  width_lat;
   logic [REPEAT_W-1:0] repeat_lat;

   logic                start_run;
   logic                pulse_end;
   logic                last_pulse;
   logic [REPEAT_W-1:0] cnt_inc;
   logic                delay_load;
   logic                delay_en;
   logic [DELAY_W-1:0]  delay_value;
   logic                delay_zero;
   logic                width_load;
   logic                width_en;
   logic [WIDTH_W-1:0]  width_value;
   logic                width_zero;

   // In IDLE the counters load straight from the ports, since the latched
   // copies are only written on that same edge.
   always_comb begin
      start_run   = (state == ST_IDLE) && START && !STOP && (WIDTH != '0);
      pulse_end   = (state == ST_HIGH) && width_zero && !STOP;
      cnt_inc     = PULSE_CNT + R_ONE;
      last_pulse  = (repeat_lat != '0) && (cnt_inc == repeat_lat);

      delay_value = (state == ST_IDLE) ? (DELAY - D_ONE) : (delay_lat - D_ONE);
      width_value = (state == ST_IDLE) ? (WIDTH - W_ONE) : (width_lat - W_ONE);

      delay_load  = (start_run && (DELAY != '0)) ||
                    (pulse_end && !last_pulse && (delay_lat != '0));
      width_load  = (start_run && (DELAY == '0)) ||
                    ((state == ST_WAIT) && delay_zero && !STOP) ||
                    (pulse_end && !last_pulse && (delay_lat == '0));
      delay_en    = (state == ST_WAIT);
      width_en    = (state == ST_HIGH);
   end

   load_down_counter #(.W(DELAY_W)) u_delay_cnt (
      .clk        (CLK),
      .rst        (RESET),
      .load       (delay_load),
      .en         (delay_en),
      .load_value (delay_value),
      .zero       (delay_zero)
   );

   load_down_counter #(.W(WIDTH_W)) u_width_cnt (
      .clk        (CLK),
      .rst        (RESET),
      .load       (width_load),
      .en         (width_en),
      .load_value (width_value),
      .zero       (width_zero)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         delay_lat  <= '0;
         width_lat  <= '0;
         repeat_lat <= '0;
         PULSE      <= 1'b0;
         BUSY       <= 1'b0;
         TASK_DONE  <= 1'b0;
         PULSE_CNT  <= '0;
      end else begin
         TASK_DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  delay_lat  <= DELAY;
                  width_lat  <= WIDTH;
                  repeat_lat <= REPEAT;
                  BUSY       <= 1'b1;
                  if (start_run) begin
                     PULSE_CNT <= '0;
                     if (DELAY == '0) begin
                        state <= ST_HIGH;
                        PULSE <= 1'b1;
                     end else begin
                        state <= ST_WAIT;
                     end
                  end else begin
                     // Zero-work start still completes the handshake.
                     state     <= ST_DONE;
                     TASK_DONE <= 1'b1;
                  end
               end
            end

            ST_WAIT: begin
               if (STOP) begin
                  state     <= ST_DONE;
                  TASK_DONE <= 1'b1;
               end else if (delay_zero) begin
                  state <= ST_HIGH;
                  PULSE <= 1'b1;
               end
            end

            ST_HIGH: begin
               if (STOP) begin
                  // Abort mid-pulse: the partial pulse is not counted.
                  state     <= ST_DONE;
                  PULSE     <= 1'b0;
                  TASK_DONE <= 1'b1;
               end else if (width_zero) begin
                  PULSE_CNT <= cnt_inc;
                  state     <= state_after_pulse(last_pulse, delay_lat != '0);
                  PULSE     <= !last_pulse && (delay_lat == '0);
                  TASK_DONE <= last_pulse;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               PULSE <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_task_pulse_gen.sv
// Directed bench for task_pulse_gen: cycle-by-cycle expected PULSE/BUSY/TASK_DONE
// windows after each START, plus abort, ignore and reset scenarios.
module tb_task_pulse_gen;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic        STOP;
   logic [15:0] DELAY;
   logic [15:0] WIDTH;
   logic [7:0]  REPEAT;
   logic        PULSE;
   logic        BUSY;
   logic        TASK_DONE;
   logic [7:0]  PULSE_CNT;

   int tests = 0;
   int fails = 0;

   task_pulse_gen #(.DELAY_W(16), .WIDTH_W(16), .REPEAT_W(8)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .STOP      (STOP),
      .DELAY     (DELAY),
      .WIDTH     (WIDTH),
      .REPEAT    (REPEAT),
      .PULSE     (PULSE),
      .BUSY      (BUSY),
      .TASK_DONE (TASK_DONE),
      .PULSE_CNT (PULSE_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Cycle c is the clock period following the c-th edge after START was
   // driven (edge 1 samples START). act 1 raises STOP for one edge, act 2
   // fires a second START with changed configuration.
   task automatic run_window(input string tag, input int n,
                             input logic [63:0] pm, input logic [63:0] bm,
                             input logic [63:0] dm, input int act_cyc, input int act);
      for (int c = 1; c <= n; c++) begin
         tick();
         START = 1'b0;
         STOP  = 1'b0;
         chk($sformatf("%s pulse c%0d", tag, c), {31'd0, PULSE},     {31'd0, pm[c]});
         chk($sformatf("%s busy c%0d",  tag, c), {31'd0, BUSY},      {31'd0, bm[c]});
         chk($sformatf("%s done c%0d",  tag, c), {31'd0, TASK_DONE}, {31'd0, dm[c]});
         if (c == act_cyc && act == 1) STOP = 1'b1;
         if (c == act_cyc && act == 2) begin
            START  = 1'b1;
            DELAY  = 16'd5;
            WIDTH  = 16'd7;
            REPEAT = 8'd9;
         end
      end
   endtask

   task automatic launch(input int d, input int w, input int r, input logic stp);
      DELAY  = 16'(d);
      WIDTH  = 16'(w);
      REPEAT = 8'(r);
      STOP   = stp;
      START  = 1'b1;
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; STOP = 1'b0;
      DELAY = '0; WIDTH = '0; REPEAT = '0;
      tick(); tick();
      chk("reset pulse", {31'd0, PULSE}, 32'd0);
      chk("reset busy",  {31'd0, BUSY},  32'd0);
      chk("reset done",  {31'd0, TASK_DONE}, 32'd0);
      chk("reset cnt",   {24'd0, PULSE_CNT}, 32'd0);
      RESET = 1'b0;
      tick();

      launch(3, 2, 2, 1'b0);
      run_window("d3w2r2", 12, rng(4, 5) | rng(9, 10), rng(1, 11), rng(11, 11), 0, 0);
      chk("d3w2r2 cnt", {24'd0, PULSE_CNT}, 32'd2);
      $display("[TB] task D=3 W=2 R=2 complete");

      launch(0, 1, 4, 1'b0);
      run_window("d0w1r4", 6, rng(1, 4), rng(1, 5), rng(5, 5), 0, 0);
      chk("d0w1r4 cnt", {24'd0, PULSE_CNT}, 32'd4);
      $display("[TB] task D=0 W=1 R=4 complete");

      launch(1, 1, 0, 1'b0);
      run_window("stop", 14, rng(2, 2) | rng(4, 4) | rng(6, 6) | rng(8, 8) | rng(10, 10) | rng(12, 12),
                 rng(1, 13), rng(13, 13), 12, 1);
      chk("stop cnt", {24'd0, PULSE_CNT}, 32'd5);
      $display("[TB] task R=0 stopped in 6th pulse complete");

      launch(4, 0, 3, 1'b0);
      run_window("w0", 3, 64'd0, rng(1, 1), rng(1, 1), 0, 0);
      $display("[TB] task WIDTH=0 complete");

      launch(2, 2, 3, 1'b1);
      run_window("startstop", 3, 64'd0, rng(1, 1), rng(1, 1), 0, 0);
      $display("[TB] task START+STOP complete");

      launch(2, 1, 2, 1'b0);
      run_window("ignore", 9, rng(3, 3) | rng(6, 6), rng(1, 7), rng(7, 7), 3, 2);
      chk("ignore cnt", {24'd0, PULSE_CNT}, 32'd2);
      $display("[TB] task with ignored restart complete");

      launch(0, 5, 1, 1'b0);
      tick(); START = 1'b0;
      tick(); tick();
      chk("prerst pulse", {31'd0, PULSE}, 32'd1);
      #2 RESET = 1'b1;
      #1;
      chk("rst pulse", {31'd0, PULSE}, 32'd0);
      chk("rst busy",  {31'd0, BUSY},  32'd0);
      chk("rst done",  {31'd0, TASK_DONE}, 32'd0);
      chk("rst cnt",   {24'd0, PULSE_CNT}, 32'd0);
      tick(); tick();
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("postrst done %0d", i), {31'd0, TASK_DONE}, 32'd0);
         chk($sformatf("postrst busy %0d", i), {31'd0, BUSY}, 32'd0);
      end
      launch(1, 1, 1, 1'b0);
      run_window("afterrst", 4, rng(2, 2), rng(1, 3), rng(3, 3), 0, 0);
      chk("afterrst cnt", {24'd0, PULSE_CNT}, 32'd1);
      $display("[TB] task after mid-pulse reset complete");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
